// File: rtl/wb_pkg.sv
// Shared widths, writeback entry layout and occupancy states for the writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W = 192;
  localparam int unsigned REG_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              vec;
  } wb_entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  function automatic occ_e occ_state(logic [1:0] count);
    case (count)
      2'd0:    return StEmpty;
      2'd1:    return StOne;
      default: return StFull;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order buffer; entry 0 is always the head, unused slots are held at zero.
module wb_fifo
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  wb_entry_t  din,
  output wb_entry_t  head,
  output logic [1:0] count
);

  wb_entry_t  mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      mem0_d  = '0;
      mem1_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) mem0_d = din;
          else                 mem1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          mem0_d  = mem1_q;
          mem1_d  = '0;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            mem0_d = din;
          end else begin
            mem0_d = mem1_q;
            mem1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign count = count_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result to write back, buffers it two deep, and counts
// entries consumed by the register files.
module writeback_stage #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned REG_W  = wb_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic              VecOp,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] rdv,
  input  logic [DATA_W-1:0] rds,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wbData,
  output logic [REG_W-1:0]  wbRd,
  output logic              wbVec,
  output logic [31:0]       retired
);

  import wb_pkg::*;

  wb_entry_t  din, head;
  logic [1:0] count;
  occ_e       state;
  logic       accept, push, pop;
  logic [31:0] retired_q;

  // Handshake is decoded from registered occupancy only, so reset clears it immediately.
  assign state     = occ_state(count);
  assign in_ready  = (state != StFull);
  assign out_valid = (state != StEmpty);

  assign accept = in_valid && in_ready && !flush;
  assign push   = accept && regWrite;
  assign pop    = out_valid && out_ready && !flush;

  always_comb begin
    din     = '0;
    din.rd  = rd;
    din.vec = VecOp;
    if (!memToReg)  din.data = aluResult;
    else if (VecOp) din.data = rdv;
    else            din.data = rds;
  end

  wb_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 32'd0;
    end else if (pop) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign wbData  = out_valid ? head.data : '0;
  assign wbRd    = out_valid ? head.rd   : '0;
  assign wbVec   = out_valid ? head.vec  : 1'b0;
  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed pushes queue expected entries, a monitor
// compares each consumed head entry; direct checks cover handshake, flush, reset and wrap.
module tb_writeback_stage;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic              regWrite, memToReg, VecOp;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] aluResult, rdv, rds;
  logic              flush;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] wbData;
  logic [REG_W-1:0]  wbRd;
  logic              wbVec;
  logic [31:0]       retired;

  int tests = 0;
  int fails = 0;
  wb_entry_t sb[$];
  logic [31:0] base;
  logic [DATA_W-1:0] pat_aa, pat_55;

  writeback_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .regWrite  (regWrite),
    .memToReg  (memToReg),
    .VecOp     (VecOp),
    .rd        (rd),
    .aluResult (aluResult),
    .rdv       (rdv),
    .rds       (rds),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wbData    (wbData),
    .wbRd      (wbRd),
    .wbVec     (wbVec),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction; push the expected writeback entry when it should be stored.
  task automatic drive(input logic wr, input logic m2r, input logic vec, input logic [REG_W-1:0] r,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] v,
                       input logic [DATA_W-1:0] s, input logic expect_store);
    wb_entry_t e;
    in_valid  = 1'b1;
    regWrite  = wr;
    memToReg  = m2r;
    VecOp     = vec;
    rd        = r;
    aluResult = alu;
    rdv       = v;
    rds       = s;
    e.rd   = r;
    e.vec  = vec;
    e.data = !m2r ? alu : (vec ? v : s);
    if (expect_store) sb.push_back(e);
  endtask

  // Monitor: every consumed head entry must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !flush && !rst) begin
        if (sb.size() == 0) begin
          check("unexpected_entry", {{(DATA_W-1){1'b0}}, out_valid}, '0);
        end else begin
          wb_entry_t e;
          e = sb.pop_front();
          check("sb_data", wbData, e.data);
          check("sb_rd", DATA_W'(wbRd), DATA_W'(e.rd));
          check("sb_vec", DATA_W'(wbVec), DATA_W'(e.vec));
        end
      end
    end
  end

  initial begin
    pat_aa = {24{8'hAA}};
    pat_55 = {24{8'h55}};
    rst = 1'b1; in_valid = 1'b0; regWrite = 1'b0; memToReg = 1'b0; VecOp = 1'b0;
    rd = '0; aluResult = '0; rdv = '0; rds = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", DATA_W'(out_valid), '0);
    check("rst_in_ready", DATA_W'(in_ready), 1);
    check("rst_retired", DATA_W'(retired), '0);
    check("rst_wbData", wbData, '0);
    step();
    rst = 1'b0;

    // Single vector load
    out_ready = 1'b1;
    drive(1, 1, 1, 4'd3, '0, pat_aa, pat_55, 1);
    step();
    in_valid = 1'b0;
    check("load_out_valid", DATA_W'(out_valid), 1);
    check("load_wbRd", DATA_W'(wbRd), 3);
    step();
    check("load_retired", DATA_W'(retired), 1);
    check("load_drained", DATA_W'(out_valid), '0);

    // Scalar load and ALU select
    drive(1, 1, 0, 4'd4, 192'h99, pat_aa, pat_55, 1);
    step();
    drive(1, 0, 0, 4'd6, 192'h1234, pat_aa, pat_55, 1);
    step();
    in_valid = 1'b0;
    step();
    check("sel_retired", DATA_W'(retired), 3);

    // Backpressure: fill, third push refused, drain in order
    out_ready = 1'b0;
    base = retired;
    drive(1, 0, 0, 4'd5, 192'd5, '0, '0, 1);
    step();
    drive(1, 0, 0, 4'd7, 192'd7, '0, '0, 1);
    step();
    check("full_in_ready", DATA_W'(in_ready), '0);
    drive(1, 0, 0, 4'd9, 192'd9, '0, '0, 0);
    step();
    in_valid = 1'b0;
    check("full_hold_data", wbData, 192'd5);
    check("full_hold_rd", DATA_W'(wbRd), 5);
    out_ready = 1'b1;
    step();
    check("full_next_data", wbData, 192'd7);
    step();
    check("bp_retired", DATA_W'(retired - base), 2);
    check("bp_empty", DATA_W'(out_valid), '0);

    // Non-writing instruction
    base = retired;
    drive(0, 0, 0, 4'd8, 192'd8, '0, '0, 0);
    check("nowr_in_ready", DATA_W'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("nowr_out_valid", DATA_W'(out_valid), '0);
    step();
    check("nowr_retired", retired, base);

    // Simultaneous push/pop in ONE
    out_ready = 1'b0;
    drive(1, 0, 0, 4'd1, 192'h11, '0, '0, 1);
    step();
    out_ready = 1'b1;
    drive(1, 0, 0, 4'd2, 192'h22, '0, '0, 1);
    step();
    in_valid = 1'b0;
    check("pp_out_valid", DATA_W'(out_valid), 1);
    check("pp_in_ready", DATA_W'(in_ready), 1);
    check("pp_wbRd", DATA_W'(wbRd), 2);
    step();

    // Flush from FULL with a same-cycle push
    out_ready = 1'b0;
    base = retired;
    drive(1, 0, 1, 4'd10, 192'hA, '0, '0, 0);
    step();
    drive(1, 0, 1, 4'd11, 192'hB, '0, '0, 0);
    step();
    flush = 1'b1;
    drive(1, 0, 1, 4'd12, 192'hC, '0, '0, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", DATA_W'(out_valid), '0);
    check("flush_in_ready", DATA_W'(in_ready), 1);
    check("flush_wbData", wbData, '0);
    // Flush in ONE while a pop is offered must not retire
    drive(1, 0, 0, 4'd13, 192'hD, '0, '0, 0);
    step();
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_pop_retired", retired, base);
    check("flush_pop_empty", DATA_W'(out_valid), '0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1, 0, 0, 4'd14, 192'hE, '0, '0, 0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_out_valid", DATA_W'(out_valid), '0);
    check("arst_retired", DATA_W'(retired), '0);
    check("arst_in_ready", DATA_W'(in_ready), 1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1, 1, 0, 4'd15, '0, '0, pat_55, 1);
    step();
    in_valid = 1'b0;
    check("resume_out_valid", DATA_W'(out_valid), 1);
    step();
    check("resume_retired", DATA_W'(retired), 1);

    // Counter wrap
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    check("wrap_preload", DATA_W'(retired), 32'hFFFF_FFFF);
    drive(1, 0, 0, 4'd2, 192'h77, '0, '0, 1);
    step();
    in_valid = 1'b0;
    step();
    check("wrap_retired", DATA_W'(retired), '0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check("sb_drained", DATA_W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_W, 192, width of vector, scalar and ALU data words.
REQ-002 SHALL have parameter REG_W, 4, register-index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  memory-access stage presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 SHALL have port regWrite, memToReg, VecOp  input  1 each  write enable, load-result select, vector-destination flag.
REQ-008 SHALL have port rd  input  REG_W  destination register index.
REQ-009 SHALL have port aluResult, rdv, rds  input  DATA_W each  ALU result, vector read data, scalar read data from memory access.
REQ-010 SHALL have port flush  input  1  discard all buffered instructions.
REQ-011 SHALL have port out_valid  output  1  writeback entry presented to register files.
REQ-012 SHALL have port out_ready  input  1  register files consume the entry.
REQ-013 SHALL have port wbData  output  DATA_W; wbRd  output  REG_W; wbVec  output  1  head-entry data, index, vector flag.
REQ-014 SHALL have port retired  output  32  count of entries consumed.

Function
REQ-015 SHALL hold instructions in a 2-entry in-order buffer; states EMPTY, ONE, FULL from occupancy count.
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready SHALL be derived only from registered state.
REQ-017 SHALL accept (push) when in_valid && in_ready && !flush.
REQ-018 SHALL select data at accept: memToReg=0 -> aluResult; memToReg=1 and VecOp=1 -> rdv; memToReg=1 and VecOp=0 -> rds.
REQ-019 SHALL discard accepted instructions with regWrite=0: accepted (handshake completes) but not stored, no state change.
REQ-020 SHALL assert out_valid in ONE and FULL, presenting the oldest entry on wbData/wbRd/wbVec; outputs are zero when EMPTY.
REQ-021 SHALL have latency of one cycle: an entry pushed at edge N is visible on outputs after edge N.
REQ-022 SHALL pop on out_valid && out_ready; push and pop in the same cycle in ONE SHALL leave state ONE with the new entry at the head.
REQ-023 SHALL keep head outputs stable while out_valid && !out_ready.
REQ-024 SHALL on flush go to EMPTY at the next edge, ignoring any same-cycle push or pop; retired SHALL not increment on that cycle.
REQ-025 SHALL increment retired by 1 per pop, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-026 SHALL on rst (any time, including mid-handshake) clear state to EMPTY, storage to zero, retired to 0; out_valid=0, in_ready=1 while rst asserted.
REQ-027 SHALL resume accepting on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL take DATA_W, REG_W and the entry struct wb_entry_t (data, rd, vec) from shared package wb_pkg.
REQ-029 SHALL implement storage as one sub-module wb_fifo (2-entry, count, push/pop/flush); selection, handshake and counter stay in writeback_stage.

Verification
REQ-030 Single load: in_valid=1, regWrite=1, memToReg=1, VecOp=1, rd=3, rdv=0xAA..AA, out_ready=1 -> next cycle out_valid=1, wbData=0xAA..AA, wbRd=3, wbVec=1; retired=1 after pop.
REQ-031 Backpressure: out_ready=0, push ALU results 5 and 7 -> FULL, in_ready=0, third push ignored; raise out_ready -> 5 then 7 in order, retired=2.
REQ-032 Non-writing instruction: regWrite=0 with in_valid=1 -> handshake completes, out_valid stays 0, retired unchanged.
REQ-033 Simultaneous push/pop in ONE: head rd=1 popped while rd=2 pushed -> state ONE, wbRd=2 next cycle.
REQ-034 Flush and reset: FULL with flush=1 and in_valid=1 -> EMPTY next cycle, nothing stored; rst pulsed mid-stream -> out_valid=0 and retired=0 immediately, without waiting for a clock edge.
REQ-035 Wrap: preload retired to 0xFFFFFFFF via 2^32-1 pops or force, one more pop -> retired=0.
